sal_bank_ctrl: RTL and testbench

- Per-bank controller between the request decoder and the command scheduler.
- Accepts one bank request at a time (valid/ready; id, row, column, length, rd/wr). Converts it into ACT/RD/WR/PRE/REF requests toward the scheduler.
- Enforces per-bank timing (tRCD, tRP, tRAS, tRFC, tRTP, tWTP) with local countdown counters.
- One instance per DRAM bank; default policy is open-page.

---
 rtl/sal_bank_pkg.sv | 58 +++++
 rtl/sal_timing_cnt.sv | 28 ++
 rtl/sal_bank_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_sal_bank_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_bank_pkg.sv
// Shared types for the per-bank DRAM controller.
// The interface-width macros are given defaults here when the build does not
// supply them. The closed-page policy is enabled by defining SAL_BANK_AUTO_PRE_EN.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef T_RCD_WIDTH
`define T_RCD_WIDTH 5
`endif
`ifndef T_RP_WIDTH
`define T_RP_WIDTH 5
`endif
`ifndef T_RAS_WIDTH
`define T_RAS_WIDTH 6
`endif
`ifndef T_RFC_WIDTH
`define T_RFC_WIDTH 8
`endif
`ifndef T_RTP_WIDTH
`define T_RTP_WIDTH 4
`endif
`ifndef T_WTP_WIDTH
`define T_WTP_WIDTH 5
`endif

package sal_bank_pkg;

    typedef enum logic [2:0] {
        CLOSED,
        ACTIVATING,
        OPEN,
        PRECHARGING,
        REFRESHING
    } bank_state_t;

    // Command currently offered to the scheduler (at most one at a time).
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_ACT,
        CMD_RD,
        CMD_WR,
        CMD_PRE,
        CMD_REF
    } bank_cmd_t;

    // Remaining column commands minus one for the buffered request.
    typedef logic [3:0] beat_t;

endpackage

// File: rtl/sal_timing_cnt.sv
// Countdown timer for one bank timing constraint. A load of t makes is_zero
// rise exactly t cycles later; t = 0 behaves like t = 1. Saturates at zero.
module sal_timing_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] t_val,
    output logic         is_zero
);

    logic [W-1:0] cnt;

    // Load t-1 on the triggering grant, otherwise count down to zero and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (t_val == '0) ? '0 : t_val - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_zero = (cnt == '0);

endmodule

// File: rtl/sal_bank_ctrl.sv
// Per-bank controller: buffers one request and turns it into ACT/RD/WR/PRE/REF
// requests for the scheduler while enforcing the bank timing constraints.
// Define SAL_BANK_AUTO_PRE_EN for closed-page operation (auto precharge when idle).
module sal_bank_ctrl
    import sal_bank_pkg::*;
#(
    parameter logic [`DRAM_BA_WIDTH-1:0] BANK_ID = '0,
    parameter int                        CA_INC  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [`AXI_ID_WIDTH-1:0]   req_id_i,
    input  logic [`DRAM_RA_WIDTH-1:0]  req_ra_i,
    input  logic [`DRAM_CA_WIDTH-1:0]  req_ca_i,
    input  logic [3:0]                 req_len_i,
    input  logic                       req_wr_i,
    input  logic [`T_RCD_WIDTH-1:0]    t_rcd_i,
    input  logic [`T_RP_WIDTH-1:0]     t_rp_i,
    input  logic [`T_RAS_WIDTH-1:0]    t_ras_i,
    input  logic [`T_RFC_WIDTH-1:0]    t_rfc_i,
    input  logic [`T_RTP_WIDTH-1:0]    t_rtp_i,
    input  logic [`T_WTP_WIDTH-1:0]    t_wtp_i,
    input  logic                       ref_pending_i,
    output logic                       act_req_o,
    output logic                       rd_req_o,
    output logic                       wr_req_o,
    output logic                       pre_req_o,
    output logic                       ref_req_o,
    input  logic                       act_gnt_i,
    input  logic                       rd_gnt_i,
    input  logic                       wr_gnt_i,
    input  logic                       pre_gnt_i,
    input  logic                       ref_gnt_i,
    output logic [`DRAM_BA_WIDTH-1:0]  ba_o,
    output logic [`DRAM_RA_WIDTH-1:0]  ra_o,
    output logic [`DRAM_CA_WIDTH-1:0]  ca_o,
    output logic [`AXI_ID_WIDTH-1:0]   id_o
);

    localparam logic [`DRAM_CA_WIDTH-1:0] CA_STEP = CA_INC[`DRAM_CA_WIDTH-1:0];

    bank_state_t                state_q, state_d;
    bank_cmd_t                  held_q, held_d, cmd;
    logic                       run_q;
    logic                       buf_valid, buf_wr;
    logic [`AXI_ID_WIDTH-1:0]   buf_id;
    logic [`DRAM_RA_WIDTH-1:0]  buf_ra, open_row;
    logic [`DRAM_CA_WIDTH-1:0]  ca_q;
    beat_t                      beat_q;
    logic                       open_valid;
    logic                       rcd_zero, ras_zero, rp_zero, rfc_zero, rtp_zero, wtp_zero;
    logic                       act_fire, rd_fire, wr_fire, pre_fire, ref_fire, any_fire;
    logic                       accept, row_hit, pre_ok, eff_closed, eff_open;

    assign req_ready_o = run_q & ~buf_valid & ~ref_pending_i;
    assign accept      = req_valid_i & req_ready_o;
    assign row_hit     = open_valid & (open_row == buf_ra);
    assign pre_ok      = ras_zero & rtp_zero & wtp_zero;

    // A transient state whose timer has expired already behaves like its
    // destination, so the dependent request appears exactly t cycles after the grant.
    assign eff_closed = (state_q == CLOSED) |
                        ((state_q == PRECHARGING) & rp_zero) |
                        ((state_q == REFRESHING) & rfc_zero);
    assign eff_open   = (state_q == OPEN) | ((state_q == ACTIVATING) & rcd_zero);

    assign act_req_o = (cmd == CMD_ACT);
    assign rd_req_o  = (cmd == CMD_RD);
    assign wr_req_o  = (cmd == CMD_WR);
    assign pre_req_o = (cmd == CMD_PRE);
    assign ref_req_o = (cmd == CMD_REF);

    // Grants are only honoured while the matching request is high.
    assign act_fire = act_req_o & act_gnt_i;
    assign rd_fire  = rd_req_o  & rd_gnt_i;
    assign wr_fire  = wr_req_o  & wr_gnt_i;
    assign pre_fire = pre_req_o & pre_gnt_i;
    assign ref_fire = ref_req_o & ref_gnt_i;
    assign any_fire = act_fire | rd_fire | wr_fire | pre_fire | ref_fire;

    assign ba_o = BANK_ID;
    assign ra_o = buf_ra;
    assign ca_o = ca_q;
    assign id_o = buf_id;

    sal_timing_cnt #(.W(`T_RCD_WIDTH)) u_rcd (
        .clk(clk), .rst_n(rst_n), .load(act_fire), .t_val(t_rcd_i), .is_zero(rcd_zero));
    sal_timing_cnt #(.W(`T_RAS_WIDTH)) u_ras (
        .clk(clk), .rst_n(rst_n), .load(act_fire), .t_val(t_ras_i), .is_zero(ras_zero));
    sal_timing_cnt #(.W(`T_RP_WIDTH)) u_rp (
        .clk(clk), .rst_n(rst_n), .load(pre_fire), .t_val(t_rp_i), .is_zero(rp_zero));
    sal_timing_cnt #(.W(`T_RFC_WIDTH)) u_rfc (
        .clk(clk), .rst_n(rst_n), .load(ref_fire), .t_val(t_rfc_i), .is_zero(rfc_zero));
    sal_timing_cnt #(.W(`T_RTP_WIDTH)) u_rtp (
        .clk(clk), .rst_n(rst_n), .load(rd_fire), .t_val(t_rtp_i), .is_zero(rtp_zero));
    sal_timing_cnt #(.W(`T_WTP_WIDTH)) u_wtp (
        .clk(clk), .rst_n(rst_n), .load(wr_fire), .t_val(t_wtp_i), .is_zero(wtp_zero));

    // Command selection and next state; an offered command is held until granted.
    always_comb begin
        cmd     = CMD_NONE;
        state_d = state_q;
        if (!run_q) begin
            cmd = CMD_NONE;
        end else if (held_q != CMD_NONE) begin
            cmd = held_q;
        end else if (eff_closed) begin
            // Refresh goes first; a request needing an ACT waits behind it.
            if (ref_pending_i) begin
                if (rp_zero && rfc_zero) cmd = CMD_REF;
            end else if (buf_valid && rp_zero && rfc_zero) begin
                cmd = CMD_ACT;
            end
        end else if (eff_open) begin
            if (buf_valid && row_hit) begin
                cmd = buf_wr ? CMD_WR : CMD_RD;
            end else if (buf_valid || ref_pending_i) begin
                if (pre_ok) cmd = CMD_PRE;
            end
`ifdef SAL_BANK_AUTO_PRE_EN
            else if (pre_ok) begin
                cmd = CMD_PRE;
            end
`else
            else begin
                cmd = CMD_NONE;
            end
`endif
        end

        case (state_q)
            ACTIVATING:  if (rcd_zero) state_d = OPEN;
            PRECHARGING: if (rp_zero)  state_d = CLOSED;
            REFRESHING:  if (rfc_zero) state_d = CLOSED;
            default:     state_d = state_q;
        endcase
        if (act_fire) state_d = ACTIVATING;
        if (pre_fire) state_d = PRECHARGING;
        if (ref_fire) state_d = REFRESHING;

        held_d = any_fire ? CMD_NONE : cmd;
    end

    // State, held command and the out-of-reset flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLOSED;
            held_q  <= CMD_NONE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            run_q   <= 1'b1;
        end
    end

    // One-entry request buffer; freed on the grant of its last column command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_wr    <= 1'b0;
            buf_id    <= '0;
            buf_ra    <= '0;
            ca_q      <= '0;
            beat_q    <= '0;
        end else if (accept) begin
            buf_valid <= 1'b1;
            buf_wr    <= req_wr_i;
            buf_id    <= req_id_i;
            buf_ra    <= req_ra_i;
            ca_q      <= req_ca_i;
            beat_q    <= req_len_i;
        end else if (rd_fire || wr_fire) begin
            ca_q <= ca_q + CA_STEP;
            if (beat_q == '0) begin
                buf_valid <= 1'b0;
            end else begin
                beat_q <= beat_q - 1'b1;
            end
        end
    end

    // Open-row tracking: set by ACT, invalidated by PRE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_valid <= 1'b0;
            open_row   <= '0;
        end else if (act_fire) begin
            open_valid <= 1'b1;
            open_row   <= buf_ra;
        end else if (pre_fire) begin
            open_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Directed bench for sal_bank_ctrl; the closed-page branch runs when
// SAL_BANK_AUTO_PRE_EN is defined.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef T_RCD_WIDTH
`define T_RCD_WIDTH 5
`endif
`ifndef T_RP_WIDTH
`define T_RP_WIDTH 5
`endif
`ifndef T_RAS_WIDTH
`define T_RAS_WIDTH 6
`endif
`ifndef T_RFC_WIDTH
`define T_RFC_WIDTH 8
`endif
`ifndef T_RTP_WIDTH
`define T_RTP_WIDTH 4
`endif
`ifndef T_WTP_WIDTH
`define T_WTP_WIDTH 5
`endif

module tb_sal_bank_ctrl;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       req_valid_i, req_ready_o, req_wr_i;
    logic [`AXI_ID_WIDTH-1:0]   req_id_i, id_o;
    logic [`DRAM_RA_WIDTH-1:0]  req_ra_i, ra_o;
    logic [`DRAM_CA_WIDTH-1:0]  req_ca_i, ca_o;
    logic [3:0]                 req_len_i;
    logic [`T_RCD_WIDTH-1:0]    t_rcd_i;
    logic [`T_RP_WIDTH-1:0]     t_rp_i;
    logic [`T_RAS_WIDTH-1:0]    t_ras_i;
    logic [`T_RFC_WIDTH-1:0]    t_rfc_i;
    logic [`T_RTP_WIDTH-1:0]    t_rtp_i;
    logic [`T_WTP_WIDTH-1:0]    t_wtp_i;
    logic                       ref_pending_i;
    logic act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o;
    logic act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i;
    logic [`DRAM_BA_WIDTH-1:0]  ba_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sal_bank_ctrl #(.BANK_ID(3'd5), .CA_INC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_id_i(req_id_i), .req_ra_i(req_ra_i), .req_ca_i(req_ca_i),
        .req_len_i(req_len_i), .req_wr_i(req_wr_i),
        .t_rcd_i(t_rcd_i), .t_rp_i(t_rp_i), .t_ras_i(t_ras_i),
        .t_rfc_i(t_rfc_i), .t_rtp_i(t_rtp_i), .t_wtp_i(t_wtp_i),
        .ref_pending_i(ref_pending_i),
        .act_req_o(act_req_o), .rd_req_o(rd_req_o), .wr_req_o(wr_req_o),
        .pre_req_o(pre_req_o), .ref_req_o(ref_req_o),
        .act_gnt_i(act_gnt_i), .rd_gnt_i(rd_gnt_i), .wr_gnt_i(wr_gnt_i),
        .pre_gnt_i(pre_gnt_i), .ref_gnt_i(ref_gnt_i),
        .ba_o(ba_o), .ra_o(ra_o), .ca_o(ca_o), .id_o(id_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clr_gnt();
        act_gnt_i = 1'b0; rd_gnt_i = 1'b0; wr_gnt_i = 1'b0;
        pre_gnt_i = 1'b0; ref_gnt_i = 1'b0;
    endtask

    task automatic send(input logic [`DRAM_RA_WIDTH-1:0] ra, input logic [`DRAM_CA_WIDTH-1:0] ca,
                        input logic [3:0] len, input logic wr, input logic [`AXI_ID_WIDTH-1:0] id);
        req_valid_i = 1'b1; req_ra_i = ra; req_ca_i = ca;
        req_len_i = len; req_wr_i = wr; req_id_i = id;
    endtask

    task automatic pulse_reset();
        step();
        rst_n = 1'b0; req_valid_i = 1'b0; ref_pending_i = 1'b0;
        clr_gnt();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; req_wr_i = 1'b0;
        req_id_i = '0; req_ra_i = '0; req_ca_i = '0; req_len_i = '0;
        ref_pending_i = 1'b1;
        clr_gnt();
        t_rcd_i = 5'd3; t_rp_i = 5'd2; t_ras_i = 6'd6;
        t_rfc_i = 8'd10; t_rtp_i = 4'd1; t_wtp_i = 5'd4;

        // Reset state, refresh demand present but masked.
        step(); #1;
        chk("rst_ref_req", 32'(ref_req_o), 32'd0);
        chk("rst_act_req", 32'(act_req_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_ra", 32'(ra_o), 32'd0);
        chk("rst_ca", 32'(ca_o), 32'd0);
        chk("rst_id", 32'(id_o), 32'd0);
        step();
        ref_pending_i = 1'b0; rst_n = 1'b1;
        step(); #1;
        chk("ready_after_rst", 32'(req_ready_o), 32'd1);
        chk("ba_const", 32'(ba_o), 32'd5);

        // Grants with no request must be ignored.
        act_gnt_i = 1'b1; rd_gnt_i = 1'b1; wr_gnt_i = 1'b1; pre_gnt_i = 1'b1; ref_gnt_i = 1'b1;
        step(); clr_gnt();

        // Read ra=0x12 ca=0 len=1, tRCD=3.
        send(14'h12, 10'h0, 4'd1, 1'b0, 4'd3);
        step(); req_valid_i = 1'b0; #1;
        chk("t1_act_req", 32'(act_req_o), 32'd1);
        chk("t1_ra", 32'(ra_o), 32'h12);
        chk("t1_ready_busy", 32'(req_ready_o), 32'd0);
        act_gnt_i = 1'b1;                        // G
        step(); act_gnt_i = 1'b0; #1;
        chk("t1_act_drop", 32'(act_req_o), 32'd0);
        chk("t1_rcd_g1", 32'(rd_req_o), 32'd0);
        step(); #1;
        chk("t1_rcd_g2", 32'(rd_req_o), 32'd0);
        step(); #1;
        chk("t1_rd_g3", 32'(rd_req_o), 32'd1);
        chk("t1_ca0", 32'(ca_o), 32'h0);
        chk("t1_id", 32'(id_o), 32'd3);
        rd_gnt_i = 1'b1;
        step(); rd_gnt_i = 1'b0; #1;
        chk("t1_rd2", 32'(rd_req_o), 32'd1);
        chk("t1_ca8", 32'(ca_o), 32'h8);
        chk("t1_ready_mid", 32'(req_ready_o), 32'd0);
        rd_gnt_i = 1'b1;
        step(); rd_gnt_i = 1'b0; #1;             // G+5
        chk("t1_rd_done", 32'(rd_req_o), 32'd0);
        chk("t1_ready_back", 32'(req_ready_o), 32'd1);

`ifndef SAL_BANK_AUTO_PRE_EN
        // Open page: idle row stays open.
        step(); step(); #1;
        chk("open_page_idle", 32'(pre_req_o), 32'd0);
        // Write to ra=0x34: miss on open row 0x12.
        send(14'h34, 10'h10, 4'd0, 1'b1, 4'd7);
        step(); req_valid_i = 1'b0; #1;
        chk("t2_pre_req", 32'(pre_req_o), 32'd1);
        chk("t2_no_act", 32'(act_req_o), 32'd0);
        pre_gnt_i = 1'b1;                        // P
        step(); pre_gnt_i = 1'b0; #1;
        chk("t2_rp_p1", 32'(act_req_o), 32'd0);
        step(); #1;
        chk("t2_act_p2", 32'(act_req_o), 32'd1);
        chk("t2_ra", 32'(ra_o), 32'h34);
        act_gnt_i = 1'b1;                        // A2
        step(); act_gnt_i = 1'b0;
        step(); #1;
        chk("t2_wr_a2", 32'(wr_req_o), 32'd0);
        step(); #1;
        chk("t2_wr_a3", 32'(wr_req_o), 32'd1);
        chk("t2_wr_ca", 32'(ca_o), 32'h10);
        chk("t2_wr_id", 32'(id_o), 32'd7);
        wr_gnt_i = 1'b1;                         // W
        step(); wr_gnt_i = 1'b0;
        send(14'h34, 10'h20, 4'd0, 1'b0, 4'd2); #1;
        chk("t3_wr_drop", 32'(wr_req_o), 32'd0);
        step(); req_valid_i = 1'b0; #1;
        chk("t3_rd_not_blocked", 32'(rd_req_o), 32'd1);
        chk("t3_rd_ca", 32'(ca_o), 32'h20);
        rd_gnt_i = 1'b1;
        step(); rd_gnt_i = 1'b0;
        send(14'h34, 10'h30, 4'd0, 1'b1, 4'd4);
        step(); req_valid_i = 1'b0; #1;
        chk("t3_wr2", 32'(wr_req_o), 32'd1);
        wr_gnt_i = 1'b1;                         // W2
        step(); wr_gnt_i = 1'b0;
        send(14'h56, 10'h0, 4'd0, 1'b0, 4'd1);
        step(); req_valid_i = 1'b0; #1;
        chk("t3_wtp_w2", 32'(pre_req_o), 32'd0);
        step(); #1;
        chk("t3_wtp_w3", 32'(pre_req_o), 32'd0);
        step(); #1;
        chk("t3_pre_w4", 32'(pre_req_o), 32'd1);
        pre_gnt_i = 1'b1;
        step(); pre_gnt_i = 1'b0;
        step(); #1;
        chk("t3_act_56", 32'(act_req_o), 32'd1);
        act_gnt_i = 1'b1;                        // A3
        step(); act_gnt_i = 1'b0;
        step(); step(); #1;
        chk("t4_rd_56", 32'(rd_req_o), 32'd1);
        rd_gnt_i = 1'b1;
        // Refresh with row open: PRE waits for tRAS from A3.
        step(); rd_gnt_i = 1'b0; ref_pending_i = 1'b1; #1;
        chk("t4_ready_ref", 32'(req_ready_o), 32'd0);
        chk("t4_ras_a4", 32'(pre_req_o), 32'd0);
        step(); #1;
        chk("t4_ras_a5", 32'(pre_req_o), 32'd0);
        step(); #1;
        chk("t4_pre_a6", 32'(pre_req_o), 32'd1);
        pre_gnt_i = 1'b1;
        step(); pre_gnt_i = 1'b0; #1;
        chk("t4_ref_rp", 32'(ref_req_o), 32'd0);
        step(); #1;
        chk("t4_ref_req", 32'(ref_req_o), 32'd1);
        chk("t4_ready_low", 32'(req_ready_o), 32'd0);
        ref_gnt_i = 1'b1;                        // F
        step(); ref_gnt_i = 1'b0; ref_pending_i = 1'b0;
        send(14'h56, 10'h0, 4'd0, 1'b0, 4'd6); #1;
        chk("t4_ref_drop", 32'(ref_req_o), 32'd0);
        step(); req_valid_i = 1'b0;
        for (int i = 0; i < 7; i++) step();
        #1;
        chk("t4_rfc_f9", 32'(act_req_o), 32'd0);
        step(); #1;
        chk("t4_act_f10", 32'(act_req_o), 32'd1);
        act_gnt_i = 1'b1;
        step(); act_gnt_i = 1'b0;
`else
        // Closed page: precharge once tRAS expires with the buffer empty.
        step(); #1;
        chk("ap_t1_pre", 32'(pre_req_o), 32'd1);
        pulse_reset();
        t_rtp_i = 4'd2; t_ras_i = 6'd1;
        send(14'h40, 10'h0, 4'd0, 1'b0, 4'd9);
        step(); req_valid_i = 1'b0; #1;
        chk("ap_act", 32'(act_req_o), 32'd1);
        act_gnt_i = 1'b1;
        step(); act_gnt_i = 1'b0;
        step(); step(); #1;
        chk("ap_rd", 32'(rd_req_o), 32'd1);
        rd_gnt_i = 1'b1;                         // R
        step(); rd_gnt_i = 1'b0; #1;
        chk("ap_rtp_r1", 32'(pre_req_o), 32'd0);
        step(); #1;
        chk("ap_pre_r2", 32'(pre_req_o), 32'd1);
        pre_gnt_i = 1'b1;
        step(); pre_gnt_i = 1'b0;
        t_rtp_i = 4'd1; t_ras_i = 6'd6;
`endif

        // tRCD=0 behaves as 1, column address wraps, then reset mid-request.
        pulse_reset();
        t_rcd_i = 5'd0;
        send(14'h12, 10'h3FC, 4'd1, 1'b0, 4'd5);
        step(); req_valid_i = 1'b0; #1;
        chk("w_act", 32'(act_req_o), 32'd1);
        act_gnt_i = 1'b1;
        step(); act_gnt_i = 1'b0; #1;
        chk("w_rcd0_rd", 32'(rd_req_o), 32'd1);
        chk("w_ca_start", 32'(ca_o), 32'h3FC);
        rd_gnt_i = 1'b1;
        step(); rd_gnt_i = 1'b0; #1;
        chk("w_rd2", 32'(rd_req_o), 32'd1);
        chk("w_ca_wrap", 32'(ca_o), 32'h004);
        rst_n = 1'b0; #1;
        chk("mr_rd_req", 32'(rd_req_o), 32'd0);
        chk("mr_any_req", 32'({act_req_o, wr_req_o, pre_req_o, ref_req_o}), 32'd0);
        chk("mr_ready", 32'(req_ready_o), 32'd0);
        chk("mr_ca", 32'(ca_o), 32'd0);
        chk("mr_id", 32'(id_o), 32'd0);
        step(); rst_n = 1'b1;
        step(); #1;
        chk("mr_ready_after", 32'(req_ready_o), 32'd1);
        chk("mr_dropped_rd", 32'(rd_req_o), 32'd0);
        chk("mr_dropped_act", 32'(act_req_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
